log_capture_ctrl: RTL and testbench
===================================

LOG_CAPTURE_CTRL -- requirements
Module: log_capture_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  NBT_DATA  12  per-channel I/Q sample width, 1..16
  N_CH  4  number of selectable I/Q channels
  RAM_DEPTH  32768  capture buffer depth in 32-bit words, power of 2
  N_PRETRIG  1024  samples kept before trigger, 1..RAM_DEPTH-1
  NBT_DECIM  8  decimation factor width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  i_clock  in  1  single system clock, rising edge
  i_reset  in  1  synchronous, active-low reset
  i_arm  in  1  start capture, level-sampled in IDLE/DONE
  i_abort  in  1  return to IDLE from any state
  i_mode  in  2  trigger mode: 00 immediate, 01 external edge, 10 threshold, 11 as 01
  i_trig_ext  in  1  external trigger
  i_thresh  in  NBT_DATA  signed threshold for mode 10
  i_ch_sel  in  clog2(N_CH)  logged channel
  i_data_I  in  N_CH*NBT_DATA  channel I samples, channel c at bits [(c+1)*NBT_DATA-1 -: NBT_DATA]
  i_data_Q  in  N_CH*NBT_DATA  channel Q samples, same packing
  i_valid  in  1  sample strobe (rate enable)
  i_decim  in  NBT_DECIM  store 1 of every i_decim+1 valid samples
  i_rd_en  in  1  read request
  i_rd_addr  in  clog2(RAM_DEPTH)  logical read address, 0 = oldest captured sample
  o_rd_data  out  32  read word
  o_rd_valid  out  1  o_rd_data valid
  o_state  out  3  FSM state code
  o_busy  out  1  state is PRETRIG, WAIT_TRIG or POSTTRIG
  o_done  out  1  capture complete
  o_wrapped  out  1  write pointer has wrapped since arm
  o_trig_addr  out  clog2(RAM_DEPTH)  physical address of trigger sample

Function
REQ-003 Stored word SHALL be {zero-pad to 16, I[i_ch_sel], zero-pad to 16, Q[i_ch_sel]}.
REQ-004 Memory SHALL be internal, inferred, simple dual-port, RAM_DEPTH x 32.
REQ-005 Store strobe SHALL be i_valid AND decimation counter == 0; counter increments on each i_valid, wraps to 0 after reaching i_decim, clears on arm.
REQ-006 Writes SHALL occur only on store strobes in PRETRIG, WAIT_TRIG, POSTTRIG; write pointer increments per store, wraps RAM_DEPTH-1 -> 0 and sets o_wrapped.
REQ-007 States SHALL be IDLE=0, PRETRIG=1, WAIT_TRIG=2, POSTTRIG=3, DONE=4.
REQ-008 IDLE/DONE with i_arm=1 SHALL go to PRETRIG; clear write pointer, decimation counter, o_wrapped, o_done, trigger latch.
REQ-009 PRETRIG SHALL go to WAIT_TRIG after N_PRETRIG stores; triggers in PRETRIG SHALL be ignored.
REQ-010 Trigger event in WAIT_TRIG: mode 00 immediately on entry; 01/11 i_trig_ext 0->1 edge (edge register reset to 0); 10 signed I[i_ch_sel] >= i_thresh on a valid cycle.
REQ-011 On trigger SHALL latch a pending flag; the next store (same cycle included) is the trigger sample; its address goes to o_trig_addr; state -> POSTTRIG.
REQ-012 POSTTRIG SHALL count RAM_DEPTH-N_PRETRIG stores including the trigger sample, then go to DONE.
REQ-013 Physical read address SHALL be (o_trig_addr - N_PRETRIG + i_rd_addr) mod RAM_DEPTH; trigger sample at logical N_PRETRIG.
REQ-014 Reads SHALL be honoured only in IDLE/DONE: one-cycle latency, o_rd_valid=1 the cycle after i_rd_en; otherwise o_rd_valid=0, o_rd_data=0.
REQ-015 i_abort SHALL force IDLE next edge, no further writes; i_abort has priority over i_arm and trigger.
REQ-016 o_done=1 exactly in DONE.

Reset
REQ-017 i_reset=0 at an edge SHALL set state IDLE and o_rd_data, o_rd_valid, o_busy, o_done, o_wrapped, o_trig_addr, all counters and flags to 0, in any state; memory contents not cleared.

Verification (RAM_DEPTH=16, N_PRETRIG=4, sample k = I=Q=k, i_valid every cycle)
REQ-018 Mode 00, i_decim=0, arm -> samples 0..15 at addr 0..15, o_trig_addr=4, o_done after 16th store; read logical 0 -> 0, logical 4 -> 4.
REQ-019 Mode 01, edge after samples 4..33 in WAIT_TRIG -> sample 34 at addr 2, o_trig_addr=2, o_wrapped=1; logical 0 -> 30, logical 15 -> 45.
REQ-020 i_decim=2, mode 00 -> stored samples 0,3,6,...,45; logical 1 -> 3.
REQ-021 i_abort during POSTTRIG -> IDLE next edge, o_busy=0, o_done=0, no writes; re-arm completes normally.
REQ-022 i_reset=0 mid-WAIT_TRIG -> all outputs 0 next edge; i_rd_en in PRETRIG -> o_rd_valid=0.

Source files
------------

// File: rtl/log_capture_ctrl.sv
// Triggered sample-capture controller: records one selected I/Q channel into a
// circular buffer around a trigger event and serves read-back once idle or done.
module log_capture_ctrl #(
    parameter int NBT_DATA  = 12,
    parameter int N_CH      = 4,
    parameter int RAM_DEPTH = 32768,
    parameter int N_PRETRIG = 1024,
    parameter int NBT_DECIM = 8,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_arm,
    input  logic                     i_abort,
    input  logic [1:0]               i_mode,
    input  logic                     i_trig_ext,
    input  logic [NBT_DATA-1:0]      i_thresh,
    input  logic [CW-1:0]            i_ch_sel,
    input  logic [N_CH*NBT_DATA-1:0] i_data_I,
    input  logic [N_CH*NBT_DATA-1:0] i_data_Q,
    input  logic                     i_valid,
    input  logic [NBT_DECIM-1:0]     i_decim,
    input  logic                     i_rd_en,
    input  logic [AW-1:0]            i_rd_addr,
    output logic [31:0]              o_rd_data,
    output logic                     o_rd_valid,
    output logic [2:0]               o_state,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_wrapped,
    output logic [AW-1:0]            o_trig_addr
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRETRIG   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POSTTRIG  = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [AW-1:0] PRE_LAST  = AW'(N_PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(RAM_DEPTH - N_PRETRIG - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(N_PRETRIG);
    localparam bit            POST_ONE  = ((RAM_DEPTH - N_PRETRIG) == 1);

    state_t                 state_q, state_d;
    logic [NBT_DECIM-1:0]   dec_q, dec_d;
    logic [AW-1:0]          wp_q, wp_d;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          trig_addr_q, trig_addr_d;
    logic                   wrapped_q, wrapped_d;
    logic                   pend_q, pend_d;
    logic                   trig_ext_q;
    logic [31:0]            rd_data_q;
    logic                   rd_valid_q;

    logic [NBT_DATA-1:0]        sel_i, sel_q;
    logic signed [NBT_DATA-1:0] sel_i_s, thresh_s;
    logic                       capturing, store, we, trig_evt, rd_ok;
    logic [31:0]                wdata;
    logic [AW-1:0]              rd_phys;

    logic [31:0] mem [RAM_DEPTH];

    always_comb begin
        sel_i = '0;
        sel_q = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (i_ch_sel == CW'(c)) begin
                sel_i = i_data_I[c*NBT_DATA +: NBT_DATA];
                sel_q = i_data_Q[c*NBT_DATA +: NBT_DATA];
            end
        end
    end

    assign sel_i_s  = sel_i;
    assign thresh_s = i_thresh;
    // Casting the unsigned samples zero-pads each half to 16 bits
    assign wdata    = {16'(sel_i), 16'(sel_q)};

    assign capturing = (state_q == ST_PRETRIG) || (state_q == ST_WAIT_TRIG) ||
                       (state_q == ST_POSTTRIG);
    assign store     = i_valid && (dec_q == '0);
    assign we        = capturing && store && !i_abort;

    always_comb begin
        case (i_mode)
            2'b00:   trig_evt = 1'b1;
            2'b10:   trig_evt = i_valid && (sel_i_s >= thresh_s);
            default: trig_evt = i_trig_ext && !trig_ext_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        trig_addr_d = trig_addr_q;
        wrapped_d   = wrapped_q;
        pend_d      = pend_q;
        if (i_valid) dec_d = (dec_q == i_decim) ? '0 : dec_q + 1'b1;
        if (we) begin
            wp_d = wp_q + 1'b1;
            if (wp_q == '1) wrapped_d = 1'b1;
        end
        if (i_abort) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) begin
                        state_d   = ST_PRETRIG;
                        dec_d     = '0;
                        wp_d      = '0;
                        cnt_d     = '0;
                        wrapped_d = 1'b0;
                        pend_d    = 1'b0;
                    end
                end
                ST_PRETRIG: begin
                    if (store) begin
                        if (cnt_q == PRE_LAST) begin
                            state_d = ST_WAIT_TRIG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    // A trigger seen between stores stays pending until the next store
                    if (store && (pend_q || trig_evt)) begin
                        trig_addr_d = wp_q;
                        pend_d      = 1'b0;
                        cnt_d       = AW'(1);
                        state_d     = POST_ONE ? ST_DONE : ST_POSTTRIG;
                    end else if (trig_evt) begin
                        pend_d = 1'b1;
                    end
                end
                ST_POSTTRIG: begin
                    if (store) begin
                        if (cnt_q == POST_LAST) state_d = ST_DONE;
                        else                    cnt_d   = cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            dec_q       <= '0;
            wp_q        <= '0;
            cnt_q       <= '0;
            trig_addr_q <= '0;
            wrapped_q   <= 1'b0;
            pend_q      <= 1'b0;
            trig_ext_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            trig_addr_q <= trig_addr_d;
            wrapped_q   <= wrapped_d;
            pend_q      <= pend_d;
            trig_ext_q  <= i_trig_ext;
        end
    end

    always_ff @(posedge i_clock) begin
        if (we) mem[wp_q] <= wdata;
    end

    // Logical address 0 is the oldest sample, N_PRETRIG before the trigger
    assign rd_ok   = i_rd_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign rd_phys = trig_addr_q - PRE_OFS + i_rd_addr;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_ok;
            rd_data_q  <= rd_ok ? mem[rd_phys] : '0;
        end
    end

    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_state     = state_q;
    assign o_busy      = capturing;
    assign o_done      = (state_q == ST_DONE);
    assign o_wrapped   = wrapped_q;
    assign o_trig_addr = trig_addr_q;

endmodule

// File: tb/tb_log_capture_ctrl.sv
// Bench for log_capture_ctrl with a 16-word buffer and 4 pre-trigger samples;
// read-back words are queued when requested and compared when o_rd_valid rises.
module tb_log_capture_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset, i_arm, i_abort, i_trig_ext, i_valid, i_rd_en;
    logic [1:0]  i_mode, i_ch_sel;
    logic [11:0] i_thresh;
    logic [47:0] i_data_I, i_data_Q;
    logic [7:0]  i_decim;
    logic [3:0]  i_rd_addr, o_trig_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_valid, o_busy, o_done, o_wrapped;
    logic [2:0]  o_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          ch_idx   = 2;
    logic [31:0] exp_q[$];

    log_capture_ctrl #(.NBT_DATA(12), .N_CH(4), .RAM_DEPTH(16), .N_PRETRIG(4), .NBT_DECIM(8)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_arm(i_arm), .i_abort(i_abort),
        .i_mode(i_mode), .i_trig_ext(i_trig_ext), .i_thresh(i_thresh), .i_ch_sel(i_ch_sel),
        .i_data_I(i_data_I), .i_data_Q(i_data_Q), .i_valid(i_valid), .i_decim(i_decim),
        .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_state(o_state), .o_busy(o_busy), .o_done(o_done), .o_wrapped(o_wrapped),
        .o_trig_addr(o_trig_addr)
    );

    always #5 i_clock = ~i_clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Sample v: selected channel I=v, Q=v+256; other channels hold values that
    // would trip the threshold trigger if the wrong channel were examined.
    function automatic logic [31:0] word(input int v);
        logic [11:0] a, b;
        a = 12'(v);
        b = 12'(v + 256);
        return {4'h0, a, 4'h0, b};
    endfunction

    task automatic drive_sample(input int v);
        for (int c = 0; c < 4; c++) begin
            if (c == ch_idx) begin
                i_data_I[c*12 +: 12] = 12'(v);
                i_data_Q[c*12 +: 12] = 12'(v + 256);
            end else begin
                i_data_I[c*12 +: 12] = 12'h7FF;
                i_data_Q[c*12 +: 12] = 12'h000;
            end
        end
    endtask

    task automatic rd(input int addr, input logic [31:0] exp);
        i_rd_en   = 1'b1;
        i_rd_addr = 4'(addr);
        exp_q.push_back(exp);
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic arm(input logic [1:0] mode, input int decim);
        i_mode  = mode;
        i_decim = 8'(decim);
        i_valid = 1'b0;
        i_arm   = 1'b1;
        tick();
        i_arm = 1'b0;
    endtask

    // Full capture; t_store is the store index of the trigger sample.
    task automatic capture(input string tag, input logic [1:0] mode, input int decim,
                           input int trig_k, input int t_store, input int base);
        int k;
        int exp_k;
        arm(mode, decim);
        check_eq({tag, "_state_pre"}, o_state, 1);
        check_eq({tag, "_busy"}, o_busy, 1);
        k = 0;
        while (!o_done && k < 200) begin
            drive_sample(base + k);
            i_valid    = 1'b1;
            i_trig_ext = mode[0] && (k == trig_k || k == 1);
            tick();
            k++;
        end
        i_valid    = 1'b0;
        i_trig_ext = 1'b0;
        exp_k = (t_store + 11) * (decim + 1) + 1;
        check_eq({tag, "_done"}, o_done, 1);
        check_eq({tag, "_nsamples"}, k, exp_k);
        check_eq({tag, "_state_done"}, o_state, 4);
        check_eq({tag, "_busy_done"}, o_busy, 0);
        check_eq({tag, "_wrapped"}, o_wrapped, 1);
        check_eq({tag, "_trig_addr"}, o_trig_addr, t_store % 16);
        rd(0, word(base + (t_store - 4) * (decim + 1)));
        rd(1, word(base + (t_store - 3) * (decim + 1)));
        rd(4, word(base + t_store * (decim + 1)));
        rd(15, word(base + (t_store + 11) * (decim + 1)));
        tick();
        check_eq({tag, "_rd_idle_valid"}, o_rd_valid, 0);
        check_eq({tag, "_rd_idle_data"}, o_rd_data, 0);
    endtask

    initial begin
        forever begin
            @(posedge i_clock);
            #2;
            if (o_rd_valid) begin
                if (exp_q.size() == 0) check_eq("rd_unexpected_valid", o_rd_valid, 0);
                else                   check_eq("rd_data", o_rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b0; i_arm = 1'b0; i_abort = 1'b0; i_mode = 2'b00; i_trig_ext = 1'b0;
        i_thresh = 12'd0; i_ch_sel = 2'(ch_idx); i_data_I = '0; i_data_Q = '0;
        i_valid = 1'b0; i_decim = 8'd0; i_rd_en = 1'b0; i_rd_addr = 4'd0;
        repeat (3) tick();
        check_eq("rst_state", o_state, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_wrapped", o_wrapped, 0);
        check_eq("rst_trig_addr", o_trig_addr, 0);
        check_eq("rst_rd_valid", o_rd_valid, 0);
        check_eq("rst_rd_data", o_rd_data, 0);
        i_reset = 1'b1;
        tick();

        capture("imm", 2'b00, 0, -1, 4, 0);

        // Abort partway through post-trigger capture, with a distinct data base
        arm(2'b00, 0);
        for (int k = 0; k < 8; k++) begin
            drive_sample(200 + k);
            i_valid = 1'b1;
            tick();
        end
        check_eq("abort_pre_state", o_state, 3);
        drive_sample(208);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_eq("abort_state", o_state, 0);
        check_eq("abort_busy", o_busy, 0);
        check_eq("abort_done", o_done, 0);
        check_eq("abort_trig_addr", o_trig_addr, 4);
        for (int k = 9; k < 11; k++) begin
            drive_sample(200 + k);
            tick();
        end
        i_valid = 1'b0;
        rd(3, word(203));
        rd(7, word(207));
        rd(8, word(8));
        rd(9, word(9));
        tick();

        capture("edge", 2'b01, 0, 34, 34, 0);
        capture("decim", 2'b00, 2, -1, 4, 0);
        i_thresh = 12'd20;
        capture("thresh", 2'b10, 0, -1, 20, 0);
        i_thresh = 12'hFFB;
        capture("thresh_neg", 2'b10, 0, -1, 4, 0);

        // Reads outside IDLE/DONE are refused; reset mid-capture clears everything
        arm(2'b01, 0);
        drive_sample(0);
        i_valid   = 1'b1;
        i_rd_en   = 1'b1;
        i_rd_addr = 4'd0;
        tick();
        i_rd_en = 1'b0;
        check_eq("pre_rd_valid", o_rd_valid, 0);
        check_eq("pre_rd_data", o_rd_data, 0);
        for (int k = 1; k < 20; k++) begin
            drive_sample(k);
            tick();
        end
        check_eq("wait_state", o_state, 2);
        check_eq("wait_wrapped", o_wrapped, 1);
        i_reset = 1'b0;
        tick();
        i_valid = 1'b0;
        check_eq("mid_rst_state", o_state, 0);
        check_eq("mid_rst_busy", o_busy, 0);
        check_eq("mid_rst_done", o_done, 0);
        check_eq("mid_rst_wrapped", o_wrapped, 0);
        check_eq("mid_rst_trig_addr", o_trig_addr, 0);
        check_eq("mid_rst_rd_valid", o_rd_valid, 0);
        i_reset = 1'b1;
        tick();
        tick();

        check_eq("rd_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
